ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the imem word-address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch byte address; it SHALL be word-aligned.
REQ-003 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  ADDR_W  word address, equal to pc[ADDR_W+1:2].
REQ-007 SHALL have port imem_ack  input  1  memory data valid, sampled only while imem_req=1.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-009 SHALL have port Instruction  output  32  held instruction for the decoder.
REQ-010 SHALL have port opcplus4  output  32  pc+4 of the held instruction, the link value for jal.
REQ-011 SHALL have port inst_valid  output  1  Instruction/opcplus4 valid, waiting for commit.
REQ-012 SHALL have port advance  input  1  core commits the held instruction this cycle.
REQ-013 SHALL have ports Branch, nBranch, Jmp, Jal, Jr, Zero  input  1 each  control flow of the held instruction.
REQ-014 SHALL have port imme_extend  input  32  extended branch offset, in words.
REQ-015 SHALL have port read_data_1  input  32  rs value, the jr target.
REQ-016 SHALL have port fault  output  1  sticky misaligned-target flag.

Function
REQ-017 SHALL implement states IDLE, FETCH, HOLD and HALT.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-019 imem_req SHALL be 1 exactly in FETCH; imem_addr SHALL stay stable until ack.
REQ-020 In FETCH with imem_ack=1, the unit SHALL capture imem_rdata into Instruction and pc+4 into opcplus4, and go to HOLD.
REQ-021 An ack in the same cycle req first rises SHALL be accepted: minimum latency is 1 cycle from FETCH entry to inst_valid=1.
REQ-022 imem_ack outside FETCH SHALL be ignored.
REQ-023 inst_valid SHALL be 1 exactly in HOLD; Instruction and opcplus4 SHALL be held constant there.
REQ-024 advance SHALL be ignored outside HOLD.
REQ-025 In HOLD with advance=1, the unit SHALL load pc with the next PC and go to FETCH; inst_valid SHALL be 0 from the next cycle.
REQ-026 Next PC SHALL be selected by priority Jr > (Jmp|Jal) > taken branch > sequential.
REQ-027 Jr SHALL give read_data_1.
REQ-028 Jmp|Jal SHALL give {opcplus4[31:28], Instruction[25:0], 2'b00}.
REQ-029 A taken branch, (Branch&Zero)|(nBranch&~Zero), SHALL give opcplus4 + (imme_extend<<2) with 32-bit wrap.
REQ-030 Sequential SHALL give opcplus4, wrapping at 32'hFFFF_FFFC+4 = 0.
REQ-031 If the selected target has bits [1:0] != 0 at commit, the unit SHALL set fault=1, leave pc unchanged, and go to HALT.
REQ-032 In HALT, imem_req and inst_valid SHALL be 0 until reset.
REQ-033 Control inputs SHALL be sampled only on the committing edge.

Reset
REQ-034 With reset=1 at an edge, state SHALL become IDLE, pc RESET_PC, Instruction 0, opcplus4 0, fault 0, from any state including mid-fetch.
REQ-035 While in IDLE after reset, imem_req=0 and inst_valid=0.
REQ-036 Reset SHALL take priority over ack and advance in the same cycle.

Verification
REQ-037 Zero-wait sequential case: reset, then ack with every req, advance held 1 -> imem_addr 0,1,2,3; opcplus4 4,8,12,16; each instruction takes 2 cycles.
REQ-038 Wait states: ack delayed 3 cycles -> imem_req held 1, imem_addr constant, inst_valid 0 until the ack edge.
REQ-039 Branch: pc=0x10, Branch=1, Zero=1, imme_extend=0xFFFF_FFFE, advance -> next imem_addr=(0x14-8)>>2=3. Repeat with Zero=0 -> imem_addr 5.
REQ-040 Jump: Jal with Instruction[25:0]=0x40 at opcplus4=0x1000_0004 -> fetch byte 0x1000_0100. Jr=1 and Jmp=1 with read_data_1=0x200 -> 0x200 (Jr wins).
REQ-041 Fault: Jr with read_data_1=0x202 -> fault=1, HALT, no further req; reset clears it and refetches RESET_PC.
REQ-042 Reset mid-fetch: assert reset while imem_req=1 with coincident ack -> capture ignored, Instruction=0, IDLE then FETCH at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: fetches one word at a time from imem, holds it for the
// decoder, and selects the next PC (jr / jump / branch / sequential) on commit.
module ifetch_unit #(
    parameter int unsigned ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       Instruction,
    output logic [31:0]       opcplus4,
    output logic              inst_valid,
    input  logic              advance,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic              Zero,
    input  logic [31:0]       imme_extend,
    input  logic [31:0]       read_data_1,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        taken_c;
    logic [31:0] next_pc_c;

    // The word address is a direct slice of the PC register, so it is stable
    // for the whole fetch regardless of how long the memory takes to ack.
    assign imem_addr = pc[ADDR_W+1:2];

    // Next-PC selection for the held instruction: jr > jump/jal > taken branch > pc+4.
    always_comb begin
        next_pc_c = opcplus4;
        taken_c   = (Branch & Zero) | (nBranch & ~Zero);
        if (Jr) begin
            next_pc_c = read_data_1;
        end else if (Jmp | Jal) begin
            next_pc_c = {opcplus4[31:28], Instruction[25:0], 2'b00};
        end else if (taken_c) begin
            next_pc_c = opcplus4 + (imme_extend << 2);
        end
    end

    // Fetch FSM; imem_req and inst_valid are flops that track FETCH and HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            Instruction <= 32'd0;
            opcplus4    <= 32'd0;
            fault       <= 1'b0;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        Instruction <= imem_rdata;
                        opcplus4    <= pc + 32'd4;
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        inst_valid  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        inst_valid <= 1'b0;
                        // A misaligned target stops fetching; pc keeps the faulting instruction's address.
                        if (next_pc_c[1:0] != 2'b00) begin
                            fault <= 1'b1;
                            state <= HALT;
                        end else begin
                            pc       <= next_pc_c;
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifetch_unit;

    localparam int unsigned ADDR_W = 14;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clock;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       Instruction;
    logic [31:0]       opcplus4;
    logic              inst_valid;
    logic              advance;
    logic              Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0]       imme_extend;
    logic [31:0]       read_data_1;
    logic              fault;

    ifetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Instruction(Instruction), .opcplus4(opcplus4), .inst_valid(inst_valid),
        .advance(advance), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal),
        .Jr(Jr), .Zero(Zero), .imme_extend(imme_extend), .read_data_1(read_data_1),
        .fault(fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the unit is doing (waiting / fetching / holding / stopped)
    // and the architectural values, advanced once per rising edge.
    bit          m_waiting   = 1'b0;
    bit          m_fetching  = 1'b0;
    bit          m_holding   = 1'b0;
    bit          m_stopped   = 1'b0;
    logic [31:0] m_pc        = 32'd0;
    logic [31:0] m_instr     = 32'd0;
    logic [31:0] m_link      = 32'd0;
    bit          m_fault     = 1'b0;

    function automatic logic [31:0] model_target();
        logic [31:0] t;
        if (Jr)
            t = read_data_1;
        else if (Jmp || Jal)
            t = (m_link & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
        else if ((Branch && Zero) || (nBranch && !Zero))
            t = m_link + imme_extend * 32'd4;
        else
            t = m_link;
        return t;
    endfunction

    always @(posedge clock) begin
        logic [31:0] t;
        if (reset) begin
            m_waiting = 1'b1; m_fetching = 1'b0; m_holding = 1'b0; m_stopped = 1'b0;
            m_pc = RESET_PC; m_instr = 32'd0; m_link = 32'd0; m_fault = 1'b0;
        end else if (m_waiting) begin
            m_waiting = 1'b0; m_fetching = 1'b1;
        end else if (m_fetching && imem_ack) begin
            m_instr = imem_rdata;
            m_link = m_pc + 32'd4;
            m_fetching = 1'b0; m_holding = 1'b1;
        end else if (m_holding && advance) begin
            t = model_target();
            m_holding = 1'b0;
            if (t % 4 != 0) begin
                m_fault = 1'b1; m_stopped = 1'b1;
            end else begin
                m_pc = t; m_fetching = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (check_en) begin
            check("imem_req", 32'(imem_req), 32'(m_fetching));
            check("imem_addr", 32'(imem_addr), 32'(ADDR_W'(m_pc >> 2)));
            check("inst_valid", 32'(inst_valid), 32'(m_holding));
            check("Instruction", Instruction, m_instr);
            check("opcplus4", opcplus4, m_link);
            check("fault", 32'(fault), 32'(m_fault));
        end
    end

    task automatic clear_ctrl();
        advance = 1'b0; Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0; Jal = 1'b0;
        Jr = 1'b0; Zero = 1'b0; imme_extend = 32'd0; read_data_1 = 32'd0;
    endtask

    // Pulse reset for one edge; returns at the negedge after the unit entered FETCH.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; imem_ack = 1'b0; clear_ctrl();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // From FETCH: ack with data; returns in HOLD.
    task automatic ack_step(input logic [31:0] data);
        imem_ack = 1'b1; imem_rdata = data;
        @(negedge clock);
        imem_ack = 1'b0;
    endtask

    // From HOLD: commit with the given control flow; returns in FETCH or HALT.
    task automatic commit_step(input bit jr, input bit jmp, input bit jal, input bit br,
                               input bit nbr, input bit z, input logic [31:0] imm,
                               input logic [31:0] rd1);
        advance = 1'b1; Jr = jr; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr;
        Zero = z; imme_extend = imm; read_data_1 = rd1;
        @(negedge clock);
        clear_ctrl();
    endtask

    logic [31:0] addr_q[$];
    logic [31:0] link_q[$];
    logic [31:0] rnd;

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; clear_ctrl();
        @(negedge clock);
        check_en = 1'b1;
        reset = 1'b0;
        check("reset_req", 32'(imem_req), 32'd0);
        check("reset_valid", 32'(inst_valid), 32'd0);
        check("reset_instr", Instruction, 32'd0);
        @(negedge clock);

        // Zero-wait sequential stream: ack every request, advance always high.
        imem_ack = 1'b1; advance = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imem_rdata = $urandom & 32'h03FF_FFFF;
            if (imem_req) addr_q.push_back(32'(imem_addr));
            if (inst_valid) link_q.push_back(opcplus4);
            @(negedge clock);
        end
        imem_ack = 1'b0; advance = 1'b0;
        check("seq_fetch_count", 32'(addr_q.size()), 32'd4);
        check("seq_hold_count", 32'(link_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_q.size() && i < link_q.size(); i++) begin
            check("seq_addr", addr_q[i], 32'(i));
            check("seq_link", link_q[i], 32'((i + 1) * 4));
        end

        // Wait states: three cycles without ack, request and address must hold.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", 32'(imem_addr), 32'd0);
            check("wait_valid", 32'(inst_valid), 32'd0);
            @(negedge clock);
        end
        ack_step(32'h1234_5678);
        check("wait_ack_valid", 32'(inst_valid), 32'd1);
        check("wait_ack_instr", Instruction, 32'h1234_5678);

        // Branch taken / not taken from pc=0x10.
        commit_step(1, 0, 0, 0, 0, 0, 32'd0, 32'h10);
        check("jr_to_10_addr", 32'(imem_addr), 32'd4);
        ack_step(32'h1000_0000);
        check("br_link", opcplus4, 32'h14);
        commit_step(0, 0, 0, 1, 0, 1, 32'hFFFF_FFFE, 32'd0);
        check("br_taken_addr", 32'(imem_addr), 32'd3);
        ack_step(32'd0);
        commit_step(1, 0, 0, 0, 0, 0, 32'd0, 32'h10);
        ack_step(32'd0);
        commit_step(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFE, 32'd0);
        check("br_not_taken_addr", 32'(imem_addr), 32'd5);

        // Jal region jump, then Jr beating Jmp.
        ack_step(32'd0);
        commit_step(1, 0, 0, 0, 0, 0, 32'd0, 32'h1000_0000);
        ack_step(32'h0C00_0040);
        check("jal_link", opcplus4, 32'h1000_0004);
        commit_step(0, 0, 1, 0, 0, 0, 32'd0, 32'd0);
        check("jal_addr", 32'(imem_addr), 32'h40);
        ack_step(32'h0800_0123);
        commit_step(1, 1, 0, 0, 0, 0, 32'd0, 32'h200);
        check("jr_wins_addr", 32'(imem_addr), 32'h80);

        // Misaligned jr target: sticky fault, no further requests even with ack/advance.
        ack_step(32'd0);
        commit_step(1, 0, 0, 0, 0, 0, 32'd0, 32'h202);
        imem_ack = 1'b1; advance = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("halt_fault", 32'(fault), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_valid", 32'(inst_valid), 32'd0);
            @(negedge clock);
        end
        imem_ack = 1'b0; advance = 1'b0;
        do_reset();
        check("fault_cleared", 32'(fault), 32'd0);
        check("refetch_addr", 32'(imem_addr), 32'd0);
        check("refetch_req", 32'(imem_req), 32'd1);

        // Reset coincident with ack during a fetch.
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        reset = 1'b0; imem_ack = 1'b0;
        check("rst_ack_instr", Instruction, 32'd0);
        check("rst_ack_req", 32'(imem_req), 32'd0);
        check("rst_ack_valid", 32'(inst_valid), 32'd0);
        @(negedge clock);
        check("rst_ack_refetch_req", 32'(imem_req), 32'd1);
        check("rst_ack_refetch_addr", 32'(imem_addr), 32'd0);

        // Randomized traffic checked only by the model.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            advance = ($urandom_range(0, 2) != 0);
            Jr = ($urandom_range(0, 7) == 0);
            Jmp = ($urandom_range(0, 7) == 0);
            Jal = ($urandom_range(0, 7) == 0);
            Branch = ($urandom_range(0, 3) == 0);
            nBranch = ($urandom_range(0, 3) == 0);
            Zero = 1'($urandom_range(0, 1));
            imme_extend = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64))
                                                     : 32'hFFFF_FFFF - 32'($urandom_range(0, 64));
            rnd = $urandom;
            rnd[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            read_data_1 = rnd;
            @(negedge clock);
        end

        reset = 1'b0; clear_ctrl(); imem_ack = 1'b0;
        @(negedge clock);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
